alu_seq: RTL and testbench

- Parametrised, registered successor to the 13-bit single-shot ALU in the datapath.
- Accepts one operation per start/done handshake and returns a registered result plus branch and status flags.
- Widens the opcode to 4 bits and adds logic, shift and iterative multiply operations.
- Sits between the register-file read ports and the writeback/PC-select logic; the control unit drives start and waits on done.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation request / completion bundle between the control unit and alu_seq.
// master = control unit side, slave = ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 13
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             branch_flag;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, branch_flag, zero, carry, overflow, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, branch_flag, zero, carry, overflow, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with start/done handshake, branch and status flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 14.
module alu_seq #(
  parameter int WIDTH = 13,
  parameter int SHW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUBI = 4'd3,
    OP_BR   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_SI   = 4'd6,
    OP_LI   = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_SLL  = 4'd11,
    OP_SRL  = 4'd12,
    OP_SRA  = 4'd13,
    OP_MUL  = 4'd14,
    OP_RSV  = 4'd15
  } op_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;
`endif

  localparam logic [31:0] WIDTH_U = WIDTH;

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_accept;
  logic             w_busy;
  logic             w_finish;

  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_branch;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic             r_illegal;

  logic [WIDTH-1:0] w_res;
  logic             w_br;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_amt;
  logic             w_amt_big;

`ifdef ALU_SEQ_MUL_EN
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [CNTW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_hi_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef ALU_SEQ_MUL_EN
          w_next = (op_e'(bus.op) == OP_MUL) ? S_MUL : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_IDLE;
`ifdef ALU_SEQ_MUL_EN
      // The last iteration hands over to EXEC, which does the writeback.
      S_MUL: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_EXEC;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && bus.start;
    w_finish = (r_state == S_EXEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op_e'(bus.op);
      r_a  <= bus.a;
      r_b  <= bus.b;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Right-shifting shift-add: high half accumulates a, low half drains b.
  assign w_hi_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_prod <= {{WIDTH{1'b0}}, bus.b};
    end else if (r_state == S_MUL) begin
      r_cnt  <= r_cnt + 1'b1;
      r_prod <= {w_hi_sum, r_prod[WIDTH-1:1]};
    end
  end
`endif

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_amt     = r_b[SHW-1:0];
  assign w_amt_big = ({{(32-SHW){1'b0}}, w_amt} >= WIDTH_U);

  always_comb begin
    w_res = '0;
    w_br  = 1'b0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (r_op)
      OP_ADD, OP_ADDI: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB, OP_SUBI: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_BR: begin
        w_res = r_a;
        w_br  = 1'b1;
      end
      OP_BEQ: begin
        w_res = w_sum[WIDTH-1:0];
        w_br  = (r_a == r_b);
      end
      OP_SI, OP_LI: w_res = r_b;
      OP_AND:       w_res = r_a & r_b;
      OP_OR:        w_res = r_a | r_b;
      OP_XOR:       w_res = r_a ^ r_b;
      OP_SLL:       w_res = w_amt_big ? '0 : (r_a << w_amt);
      OP_SRL:       w_res = w_amt_big ? '0 : (r_a >> w_amt);
      OP_SRA:       w_res = w_amt_big ? {WIDTH{r_a[WIDTH-1]}}
                                      : WIDTH'($signed(r_a) >>> w_amt);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        w_res = r_prod[WIDTH-1:0];
        w_c   = |r_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default:      w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_result   <= '0;
      r_branch   <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result   <= w_res;
        r_branch   <= w_br;
        r_zero     <= (w_res == '0);
        r_carry    <= w_c;
        r_overflow <= w_v;
        r_illegal  <= w_ill;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.branch_flag = r_branch;
  assign bus.zero        = r_zero;
  assign bus.carry       = r_carry;
  assign bus.overflow    = r_overflow;
  assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model plus directed literals.
// Follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;
  localparam int W   = 13;
  localparam int SHW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     br;
    bit     z;
    bit     c;
    bit     v;
    bit     ill;
    int     lat;
  } exp_t;

  typedef struct {
    int   acc;
    int   dn;
    exp_t e;
  } txn_t;

  txn_t q[$];
  exp_t held;
  int   cyc      = 0;
  bit   rst_s    = 1'b0;
  int   errors   = 0;
  int   checks   = 0;
  int   last_acc = 0;

  function automatic exp_t model(int op, longint a, longint b);
    exp_t   e;
    longint m    = longint'(1) << W;
    longint mask = m - 1;
    longint sa, sb, s;
    int     amt;
    e     = '{default: 0};
    e.lat = 1;
    sa    = (a >= m / 2) ? a - m : a;
    sb    = (b >= m / 2) ? b - m : b;
    amt   = int'(b % (longint'(1) << SHW));
    case (op)
      0, 2: begin
        e.res = (a + b) & mask;
        e.c   = (a + b) >= m;
        s     = sa + sb;
        e.v   = (s > m / 2 - 1) || (s < -(m / 2));
      end
      1, 3: begin
        e.res = (a - b) & mask;
        e.c   = a < b;
        s     = sa - sb;
        e.v   = (s > m / 2 - 1) || (s < -(m / 2));
      end
      4: begin e.res = a; e.br = 1; end
      5: begin e.res = (a + b) & mask; e.br = (a == b); end
      6, 7: e.res = b;
      8:  e.res = a & b;
      9:  e.res = a | b;
      10: e.res = a ^ b;
      11: e.res = (amt >= W) ? 0 : ((a << amt) & mask);
      12: e.res = (amt >= W) ? 0 : (a >> amt);
      13: e.res = (amt >= W) ? ((sa < 0) ? mask : 0) : ((sa >>> amt) & mask);
`ifdef ALU_SEQ_MUL_EN
      14: begin
        e.res = (a * b) & mask;
        e.c   = (a * b) >= m;
        e.lat = W + 1;
      end
`endif
      default: begin e.res = 0; e.ill = 1; end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [63:0] pk(bit bsy, bit dn, exp_t e);
    return 64'({bsy, dn, e.br, e.z, e.c, e.v, e.ill, e.res[W-1:0]});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({bus.busy, bus.done, bus.branch_flag, bus.zero, bus.carry,
                bus.overflow, bus.illegal, bus.result});
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic bit model_idle();
    return (q.size() == 0) || (q[$].dn <= cyc);
  endfunction

  task automatic push(int op, longint a, longint b);
    exp_t e;
    e = model(op, a, b);
    q.push_back('{acc: cyc + 1, dn: cyc + 1 + e.lat, e: e});
    last_acc = cyc + 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_s = reset;
  end

  // Single compare process: every cycle the whole output vector is predicted.
  always @(negedge clk) begin
    exp_t z0;
    z0 = '{default: 0};
    if (rst_s) begin
      q.delete();
      held = z0;
      chk("reset_state", dut_vec(), pk(1'b0, 1'b0, z0));
    end else if (q.size() != 0 && q[0].dn == cyc) begin
      chk("completion", dut_vec(), pk(1'b0, 1'b1, q[0].e));
      held = q[0].e;
      void'(q.pop_front());
    end else begin
      chk("hold_busy", dut_vec(),
          pk((q.size() != 0) && (cyc >= q[0].acc), 1'b0, held));
    end
  end

  task automatic issue(int op, longint a, longint b);
    int n = 0;
    @(posedge clk); #1;
    while (!model_idle() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    bus.start = 1'b1;
    bus.op    = 4'(op);
    bus.a     = W'(a);
    bus.b     = W'(b);
    push(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(string nm, longint er, bit [4:0] ef, int elat);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout cyc=%0d actual=no_done required=done", nm, cyc);
    end else begin
      chk({nm, "_val"},
          64'({bus.result, bus.branch_flag, bus.zero, bus.carry, bus.overflow, bus.illegal}),
          64'({er[W-1:0], ef}));
      chk({nm, "_lat"}, 64'(cyc - last_acc), 64'(elat));
    end
  endtask

  function automatic longint rnd_val();
    longint mask = (longint'(1) << W) - 1;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return mask;
      2:       return longint'(1) << (W - 1);
      3:       return (longint'(1) << (W - 1)) - 1;
      4:       return longint'($urandom_range(0, 15));
      default: return longint'($urandom_range(0, 32'(mask)));
    endcase
  endfunction

  initial begin
    longint ra, rb;
    int     n;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // flags order: {branch, zero, carry, overflow, illegal}
    issue(0, 8191, 1);     wait_done("add_wrap",  0,      5'b01100, 1);
    issue(0, 4095, 1);     wait_done("add_ovf",   4096,   5'b00010, 1);
    issue(1, 5, 7);        wait_done("sub_borrow", 8190,  5'b00100, 1);
    issue(5, 100, 100);    wait_done("beq_eq",    200,    5'b10000, 1);
    issue(5, 100, 101);    wait_done("beq_ne",    201,    5'b00000, 1);
    issue(13, 'h1000, 15); wait_done("sra_big",   'h1FFF, 5'b00000, 1);
    issue(12, 'h1000, 12); wait_done("srl_edge",  1,      5'b00000, 1);
    issue(11, 1, 13);      wait_done("sll_big",   0,      5'b01000, 1);
    issue(15, 3, 4);       wait_done("reserved",  0,      5'b01001, 1);
    issue(7, 0, 77);       wait_done("li_clear",  77,     5'b00000, 1);
`ifdef ALU_SEQ_MUL_EN
    issue(14, 90, 91);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = W'(1);
    bus.b     = W'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("mul_small", 8190, 5'b00000, W + 1);
    issue(14, 200, 100);   wait_done("mul_big", 3616, 5'b00100, W + 1);
    issue(14, 200, 100);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    issue(0, 2, 3);        wait_done("add_after_mul_rst", 5, 5'b00000, 1);
`else
    issue(14, 90, 91);     wait_done("mul_off", 0, 5'b01001, 1);
`endif
    issue(1, 1, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    issue(0, 2, 3);        wait_done("add_after_rst", 5, 5'b00000, 1);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 149) == 0) begin
        bus.start = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        ra        = rnd_val();
        rb        = rnd_val();
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 4'($urandom_range(0, 15));
        bus.a     = W'(ra);
        bus.b     = W'(rb);
        if (bus.start && model_idle()) push(int'(bus.op), ra, rb);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d actual=pending required=empty", cyc);
    end
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
